glyph_pixel_gen: RTL and testbench



---
 rtl/glyph_pixel_gen_pkg.sv | 67 ++++++
 rtl/glyph_sync_delay.sv | 34 +++
 rtl/glyph_pixel_gen.sv | 101 ++++++++++
 tb/tb_glyph_pixel_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pixel_gen_pkg.sv
// Shared constants, pipeline stage types and helpers for the tile/glyph pixel renderer.
package glyph_pixel_gen_pkg;

   localparam logic [9:0] H_OFFSET_DEF = 10'd145;
   localparam logic [9:0] V_OFFSET_DEF = 10'd32;
   localparam int unsigned MAP_COLS = 32'd40;
   localparam int unsigned MAP_ROWS = 32'd30;
   localparam int unsigned TILE_SIZE = 32'd16;
   localparam int unsigned PIPE_DEPTH = 32'd3;

   localparam int unsigned GLYPH_IDX_LSB = 32'd0;
   localparam int unsigned GLYPH_IDX_MSB = 32'd4;
   localparam int unsigned PAL_LSB = 32'd5;
   localparam int unsigned PAL_MSB = 32'd7;

   localparam logic [7:0] COLOR_BLACK = 8'b000_000_00;
   localparam logic [7:0] COLOR_BLUE = 8'b000_000_11;
   localparam logic [7:0] COLOR_GREEN = 8'b000_111_00;
   localparam logic [7:0] COLOR_CYAN = 8'b000_111_11;
   localparam logic [7:0] COLOR_RED = 8'b111_000_00;
   localparam logic [7:0] COLOR_MAGENTA = 8'b111_000_11;
   localparam logic [7:0] COLOR_YELLOW = 8'b111_111_00;
   localparam logic [7:0] COLOR_WHITE = 8'b111_111_11;
   localparam logic [7:0] BG_COLOR_DEF = COLOR_BLACK;

   typedef struct packed {
      logic [3:0] x_lo;
      logic [3:0] y_lo;
   } s0_t;

   typedef struct packed {
      logic [2:0] pal;
      logic [3:0] x_lo;
   } s1_t;

   typedef struct packed {
      logic bright;
      logic hsync;
      logic vsync;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{bright: 1'b0, hsync: 1'b1, vsync: 1'b1};

   function automatic logic [7:0] palette_lookup(input logic [2:0] sel);
      logic [7:0] color;
      case (sel)
         3'd0:    color = COLOR_BLACK;
         3'd1:    color = COLOR_BLUE;
         3'd2:    color = COLOR_GREEN;
         3'd3:    color = COLOR_CYAN;
         3'd4:    color = COLOR_RED;
         3'd5:    color = COLOR_MAGENTA;
         3'd6:    color = COLOR_YELLOW;
         3'd7:    color = COLOR_WHITE;
         default: color = COLOR_BLACK;
      endcase
      return color;
   endfunction

   // row*40 + col built from shifts; an out-of-range row/col still fits in 11 bits
   function automatic logic [10:0] tile_addr(input logic [4:0] row, input logic [5:0] col);
      logic [10:0] row_w;
      row_w = {6'd0, row};
      return (row_w << 5) + (row_w << 3) + {5'd0, col};
   endfunction

endpackage

// File: rtl/glyph_sync_delay.sv
// Three-stage pix_en-gated delay of {bright, hSync, vSync}, idling at {0,1,1}.
module glyph_sync_delay
   import glyph_pixel_gen_pkg::*;
(
   input  logic  clk,
   input  logic  clear,
   input  logic  pix_en,
   input  sync_t sync_in,
   output logic  mid_bright,
   output sync_t sync_out
);

   sync_t d0_r;
   sync_t d1_r;
   sync_t d2_r;

   // shift register advancing only on pixel ticks
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         d0_r <= SYNC_IDLE;
         d1_r <= SYNC_IDLE;
         d2_r <= SYNC_IDLE;
      end else if (pix_en) begin
         d0_r <= sync_in;
         d1_r <= d0_r;
         d2_r <= d1_r;
      end
   end

   // the middle tap lines up with the colour stage's decision
   assign mid_bright = d1_r.bright;
   assign sync_out = d2_r;

endmodule

// File: rtl/glyph_pixel_gen.sv
// Tile/glyph renderer: coordinates -> tile-map address -> glyph-row address -> RGB, 3 pixel ticks deep.
module glyph_pixel_gen
   import glyph_pixel_gen_pkg::*;
#(
   parameter logic [9:0] H_OFFSET = H_OFFSET_DEF,
   parameter logic [9:0] V_OFFSET = V_OFFSET_DEF,
   parameter logic [7:0] BG_COLOR = BG_COLOR_DEF
)(
   input  logic        clk,
   input  logic        clear,
   input  logic        pix_en,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic        bright_in,
   input  logic        hSync_in,
   input  logic        vSync_in,
   output logic [10:0] map_addr,
   input  logic [7:0]  map_data,
   output logic [8:0]  glyph_addr,
   input  logic [15:0] glyph_data,
   output logic [7:0]  rgb,
   output logic        bright_out,
   output logic        hSync_out,
   output logic        vSync_out
);

   logic [9:0]  x_s;
   logic [8:0]  y_s;
   logic [10:0] map_addr_s;
   s0_t         s0_next_s;
   s1_t         s1_next_s;
   logic [8:0]  glyph_addr_s;
   logic        pix_s;
   logic        mid_bright_s;
   logic [7:0]  rgb_next_s;
   sync_t       sync_in_s;
   sync_t       sync_out_s;
   s0_t         s0_r;
   s1_t         s1_r;

   // stage 0: screen coordinate to tile-map address; only y bits [8:0] matter for the row
   always_comb begin
      x_s = hCount - H_OFFSET;
      y_s = vCount[8:0] - V_OFFSET[8:0];
      map_addr_s = tile_addr(y_s[8:4], x_s[9:4]);
      s0_next_s.x_lo = x_s[3:0];
      s0_next_s.y_lo = y_s[3:0];
   end

   // stage 1: tile entry to glyph-row address
   always_comb begin
      glyph_addr_s = {map_data[GLYPH_IDX_MSB:GLYPH_IDX_LSB], s0_r.y_lo};
      s1_next_s.pal = map_data[PAL_MSB:PAL_LSB];
      s1_next_s.x_lo = s0_r.x_lo;
   end

   // stage 2: pick the glyph bit (bit 15 is leftmost) and colour it
   always_comb begin
      pix_s = glyph_data[4'd15 - s1_r.x_lo];
      if (!mid_bright_s) begin
         rgb_next_s = 8'd0;
      end else if (pix_s) begin
         rgb_next_s = palette_lookup(s1_r.pal);
      end else begin
         rgb_next_s = BG_COLOR;
      end
   end

   // pipeline registers, all gated by the pixel strobe
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         map_addr <= 11'd0;
         s0_r <= '0;
         glyph_addr <= 9'd0;
         s1_r <= '0;
         rgb <= 8'd0;
      end else if (pix_en) begin
         map_addr <= map_addr_s;
         s0_r <= s0_next_s;
         glyph_addr <= glyph_addr_s;
         s1_r <= s1_next_s;
         rgb <= rgb_next_s;
      end
   end

   assign sync_in_s = '{bright: bright_in, hsync: hSync_in, vsync: vSync_in};

   glyph_sync_delay u_sync_delay (
      .clk        (clk),
      .clear      (clear),
      .pix_en     (pix_en),
      .sync_in    (sync_in_s),
      .mid_bright (mid_bright_s),
      .sync_out   (sync_out_s)
   );

   assign bright_out = sync_out_s.bright;
   assign hSync_out = sync_out_s.hsync;
   assign vSync_out = sync_out_s.vsync;

endmodule

// File: tb/tb_glyph_pixel_gen.sv
// Scoreboard bench for glyph_pixel_gen with behavioural tile-map RAM and glyph ROM.
module tb_glyph_pixel_gen;

   logic        clk;
   logic        clear;
   logic        pix_en;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic        bright_in;
   logic        hSync_in;
   logic        vSync_in;
   logic [10:0] map_addr;
   logic [7:0]  map_data;
   logic [8:0]  glyph_addr;
   logic [15:0] glyph_data;
   logic [7:0]  rgb;
   logic        bright_out;
   logic        hSync_out;
   logic        vSync_out;

   typedef struct packed {
      logic [7:0] rgb;
      logic       b;
      logic       hs;
      logic       vs;
   } exp_t;

   logic [7:0]  map_mem [0:2047];
   logic [15:0] glyph_mem [0:511];
   logic [7:0]  pal_tab [0:7];
   exp_t        sbq [$];
   logic [8:0]  prev_gaddr;
   bit          seen [0:2047];
   int          vectors;
   int          miscompares;

   glyph_pixel_gen dut (
      .clk        (clk),
      .clear      (clear),
      .pix_en     (pix_en),
      .hCount     (hCount),
      .vCount     (vCount),
      .bright_in  (bright_in),
      .hSync_in   (hSync_in),
      .vSync_in   (vSync_in),
      .map_addr   (map_addr),
      .map_data   (map_data),
      .glyph_addr (glyph_addr),
      .glyph_data (glyph_data),
      .rgb        (rgb),
      .bright_out (bright_out),
      .hSync_out  (hSync_out),
      .vSync_out  (vSync_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous memories with 1-clk read latency
   always @(posedge clk) begin
      map_data <= map_mem[map_addr];
      glyph_data <= glyph_mem[glyph_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] out_snapshot();
      return {1'b0, rgb, map_addr, glyph_addr, bright_out, hSync_out, vSync_out};
   endfunction

   // one pixel tick, then `gap` idle clks during which everything must hold
   task automatic apply(input logic [9:0] h, input logic [9:0] v, input logic b,
                        input logic hs, input logic vs, input int gap);
      logic [9:0]  x;
      logic [9:0]  y;
      logic [10:0] a;
      logic [7:0]  e;
      logic [8:0]  ga;
      logic [15:0] sh;
      exp_t        ex;
      exp_t        got;
      logic [31:0] hold;
      int          n;
      x = h - 10'd145;
      y = v - 10'd32;
      a = 11'(y[8:4]) * 11'd40 + 11'(x[9:4]);
      e = map_mem[a];
      ga = {e[4:0], y[3:0]};
      sh = glyph_mem[ga] << x[3:0];
      ex.rgb = !b ? 8'h00 : (sh[15] ? pal_tab[e[7:5]] : 8'h00);
      ex.b = b;
      ex.hs = hs;
      ex.vs = vs;
      sbq.push_back(ex);
      hCount = h;
      vCount = v;
      bright_in = b;
      hSync_in = hs;
      vSync_in = vs;
      pix_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pix_en = 1'b0;
      chk("map_addr", 32'(map_addr), 32'(a));
      chk("glyph_addr", 32'(glyph_addr), 32'(prev_gaddr));
      prev_gaddr = ga;
      seen[map_addr] = 1'b1;
      if (sbq.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         got = sbq.pop_front();
         chk("rgb", 32'(rgb), 32'(got.rgb));
         chk("sync", 32'({bright_out, hSync_out, vSync_out}), 32'({got.b, got.hs, got.vs}));
      end
      if (bright_out == 1'b0) chk("blank_rgb", 32'(rgb), 32'd0);
      hold = out_snapshot();
      n = (gap < 1) ? 1 : gap;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("stall_hold", out_snapshot(), hold);
      end
   endtask

   task automatic reset_seq();
      logic [31:0] idle;
      exp_t        ie;
      idle = {1'b0, 8'h00, 11'd0, 9'd0, 1'b0, 1'b1, 1'b1};
      @(negedge clk);
      #2;
      clear = 1'b0;
      #1;
      chk("reset_async", out_snapshot(), idle);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pix_en = ~pix_en;
         chk("reset_hold", out_snapshot(), idle);
      end
      @(negedge clk);
      pix_en = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      sbq.delete();
      ie = '{rgb: 8'h00, b: 1'b0, hs: 1'b1, vs: 1'b1};
      sbq.push_back(ie);
      sbq.push_back(ie);
      prev_gaddr = {map_mem[0][4:0], 4'd0};
   endtask

   initial begin
      int cnt;
      vectors = 0;
      miscompares = 0;
      pal_tab = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};
      for (int i = 0; i < 2048; i++) map_mem[i] = 8'($urandom);
      for (int i = 0; i < 512; i++) glyph_mem[i] = 16'($urandom);
      map_mem[0] = 8'b010_00011;
      glyph_mem[9'b00011_0111] = 16'h8000;
      map_mem[1] = 8'b111_00100;
      for (int r = 0; r < 16; r++) glyph_mem[{5'd4, 4'(r)}] = 16'hFFFF;
      for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
      clear = 1'b0;
      pix_en = 1'b0;
      hCount = 10'd0;
      vCount = 10'd0;
      bright_in = 1'b0;
      hSync_in = 1'b1;
      vSync_in = 1'b1;
      repeat (3) @(posedge clk);
      reset_seq();

      // address corners
      apply(10'd145, 10'd32, 1'b1, 1'b1, 1'b1, 1);
      chk("addr_origin", 32'(map_addr), 32'd0);
      apply(10'd772, 10'd501, 1'b1, 1'b1, 1'b1, 1);
      chk("addr_last", 32'(map_addr), 32'd1199);

      // glyph path: tile 0, glyph 3 row 7, palette GREEN
      apply(10'd145, 10'd39, 1'b1, 1'b1, 1'b1, 1);
      apply(10'd146, 10'd39, 1'b1, 1'b1, 1'b1, 1);
      chk("glyph_addr_dir", 32'(glyph_addr), 32'(9'b00011_0111));
      apply(10'd147, 10'd39, 1'b1, 1'b1, 1'b1, 1);
      chk("rgb_green", 32'(rgb), 32'(8'b000_111_00));
      apply(10'd148, 10'd39, 1'b1, 1'b1, 1'b1, 1);
      chk("rgb_bg", 32'(rgb), 32'd0);

      // blanking over an all-ones glyph, with an hSync pulse
      apply(10'd161, 10'd32, 1'b0, 1'b0, 1'b1, 1);
      chk("hs_lat1", 32'(hSync_out), 32'd1);
      apply(10'd162, 10'd32, 1'b1, 1'b1, 1'b1, 1);
      chk("hs_lat2", 32'(hSync_out), 32'd1);
      apply(10'd163, 10'd32, 1'b1, 1'b1, 1'b1, 1);
      chk("hs_lat3", 32'(hSync_out), 32'd0);
      chk("blank_ffff", 32'(rgb), 32'd0);
      apply(10'd164, 10'd32, 1'b1, 1'b1, 1'b1, 1);
      chk("hs_after", 32'(hSync_out), 32'd1);
      chk("rgb_white", 32'(rgb), 32'hFF);

      // long stalls between ticks
      for (int i = 0; i < 6; i++)
         apply(10'($urandom_range(799, 0)), 10'($urandom_range(524, 0)),
               1'($urandom), 1'($urandom), 1'($urandom), 10);

      // reset in the middle of a white run
      for (int i = 0; i < 3; i++) apply(10'd165, 10'd33, 1'b1, 1'b1, 1'b1, 1);
      reset_seq();

      // random stream across visible and blanking regions
      for (int i = 0; i < 300; i++)
         apply(10'($urandom_range(799, 0)), 10'($urandom_range(524, 0)),
               1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(3, 1)));

      // visit every tile once: expect 1200 distinct addresses
      for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
      for (int r = 0; r < 30; r++) begin
         for (int c = 0; c < 40; c++) begin
            apply(10'(145 + 16 * c + int'($urandom_range(15, 0))),
                  10'(32 + 16 * r + int'($urandom_range(15, 0))),
                  1'b1, 1'b1, 1'b1, 1);
         end
      end
      cnt = 0;
      for (int i = 0; i < 1200; i++) cnt += int'(seen[i]);
      chk("distinct_addrs", 32'(cnt), 32'd1200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
